// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//
// Shares one single-port data SRAM between the pipeline MEM stage (cpu_*) and
// a host loader (ext_*). Requests are arbitrated only in IDLE. The CPU normally
// wins. An ext request that has been refused MAX_WAIT IDLE cycles in a row
// takes priority on the next IDLE cycle, so the loader cannot be starved.
//
// Ports
//   clk, rst                    clock, synchronous active-high reset
//   cpu_req/we/addr/wdata       MEM-stage request (read when cpu_we=0)
//   cpu_rdata, cpu_stall        read data (valid in CPU_DATA), hold pipeline
//   ext_req/we/addr/wdata       loader request, held stable until ext_ack
//   ext_ack, ext_rdata          one-cycle completion pulse, registered read data
//   mem_addr/wen/ren/wdata      SRAM command, driven only in the grant cycle
//   mem_rdata                   SRAM read data, valid one cycle after mem_ren
// -----------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int ADDR_W   = 64,
  parameter int DATA_W   = 64,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  output logic              ext_ack,
  output logic [DATA_W-1:0] ext_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wen,
  output logic              mem_ren,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  // A zero-width counter is not legal; MAX_WAIT=0 still needs one bit.
  localparam int WAIT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CPU_DATA = 2'd1,
    EXT_DATA = 2'd2
  } state_t;

  state_t              r_state;
  logic [WAIT_W-1:0]   r_wait_cnt;
  logic                r_ext_we;     // direction of the ext access in flight
  logic [DATA_W-1:0]   r_ext_rdata;

  logic                w_idle;
  logic                w_grant_ext;
  logic                w_grant_cpu;

  // Grants exist only in IDLE and never while reset is held, so no command
  // reaches the SRAM during reset.
  always_comb begin
    w_idle      = (r_state == IDLE) && !rst;
    w_grant_ext = w_idle && ext_req && (!cpu_req || (r_wait_cnt == WAIT_MAX));
    w_grant_cpu = w_idle && cpu_req && !w_grant_ext;
  end

  // SRAM command mux: issued combinationally in the grant cycle.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wen   = 1'b0;
    mem_ren   = 1'b0;
    if (w_grant_ext) begin
      mem_addr  = ext_addr;
      mem_wdata = ext_wdata;
      mem_wen   = ext_we;
      mem_ren   = !ext_we;
    end else if (w_grant_cpu) begin
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      mem_wen   = cpu_we;
      mem_ren   = !cpu_we;
    end
  end

  // Status outputs decode the state register; the rst term forces them low
  // during the reset cycle even if an access was in flight.
  always_comb begin
    ext_ack   = (r_state == EXT_DATA) && !rst;
    cpu_rdata = ((r_state == CPU_DATA) && !rst) ? mem_rdata : '0;
    // The CPU runs free when idle, when its read completes, or when its
    // write is accepted this cycle; any other request holds the pipeline.
    cpu_stall = cpu_req && !rst && (r_state != CPU_DATA) && !(w_grant_cpu && cpu_we);
  end

  assign ext_rdata = r_ext_rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_wait_cnt  <= '0;
      r_ext_we    <= 1'b0;
      r_ext_rdata <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant_ext) begin
            r_state  <= EXT_DATA;
            r_ext_we <= ext_we;
          end else if (w_grant_cpu && !cpu_we) begin
            r_state <= CPU_DATA;
          end
        end
        CPU_DATA: r_state <= IDLE;
        EXT_DATA: begin
          r_state <= IDLE;
          // Direction was latched at issue: the loader may already have
          // dropped ext_req, but the issued access still completes.
          if (!r_ext_we) begin
            r_ext_rdata <= mem_rdata;
          end
        end
        default: r_state <= IDLE;
      endcase

      // Starvation counter: counts refused IDLE cycles, saturating.
      if (!ext_req || w_grant_ext) begin
        r_wait_cnt <= '0;
      end else if ((r_state == IDLE) && (r_wait_cnt < WAIT_MAX)) begin
        r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
      end
    end
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 64, address width; DATA_W, default 64, data width; MAX_WAIT, default 4, maximum consecutive IDLE-cycle denials of an ext request before ext wins.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 cpu_req  in  1 / cpu_we  in  1 / cpu_addr  in  ADDR_W / cpu_wdata  in  DATA_W: pipeline MEM-stage access request (read when cpu_we=0).
REQ-005 cpu_rdata  out  DATA_W  read data to pipeline; cpu_stall  out  1  hold-pipeline indication.
REQ-006 ext_req  in  1 / ext_we  in  1 / ext_addr  in  ADDR_W / ext_wdata  in  DATA_W: host loader request, held stable until ext_ack.
REQ-007 ext_ack  out  1  one-cycle completion pulse; ext_rdata  out  DATA_W  registered read data.
REQ-008 mem_addr  out  ADDR_W / mem_wen  out  1 / mem_ren  out  1 / mem_wdata  out  DATA_W: single-port data SRAM command; mem_rdata  in  DATA_W, valid one cycle after mem_ren.

Function
REQ-009 The FSM SHALL have states IDLE, CPU_DATA, EXT_DATA; commands SHALL issue only in IDLE.
REQ-010 In IDLE, grant_ext SHALL be ext_req && (!cpu_req || wait_cnt==MAX_WAIT); grant_cpu SHALL be cpu_req && !grant_ext; at most one grant per cycle.
REQ-011 On a grant, mem_addr/mem_wdata SHALL carry the granted requester's addr/wdata, mem_wen=we, mem_ren=!we, in the same cycle (combinational); with no grant, mem_wen=mem_ren=0, mem_addr=0, mem_wdata=0.
REQ-012 Transitions: IDLE->CPU_DATA on grant_cpu with cpu_we=0; IDLE->EXT_DATA on any grant_ext (read or write); CPU_DATA->IDLE and EXT_DATA->IDLE unconditionally; CPU write grant SHALL stay in IDLE.
REQ-013 cpu_stall SHALL be 1 when cpu_req=1, except: IDLE with grant_cpu and cpu_we=1 (write completes at the edge, stall 0); CPU_DATA (stall 0). cpu_stall SHALL be 0 when cpu_req=0.
REQ-014 CPU read latency SHALL be exactly 1 stall cycle when granted immediately: issue cycle stall=1, next cycle (CPU_DATA) cpu_rdata=mem_rdata, stall=0.
REQ-015 cpu_rdata SHALL equal mem_rdata in CPU_DATA, 0 otherwise.
REQ-016 In EXT_DATA ext_ack SHALL be 1 for exactly that cycle; for reads ext_rdata SHALL be loaded from mem_rdata at that edge and held until the next ext read completion; ext writes SHALL leave ext_rdata unchanged.
REQ-017 wait_cnt (width ceil(log2(MAX_WAIT+1))) SHALL increment, saturating at MAX_WAIT, in each IDLE cycle with ext_req=1 and grant_ext=0; it SHALL clear on grant_ext or in any cycle with ext_req=0; it SHALL hold in CPU_DATA/EXT_DATA.
REQ-018 Simultaneous cpu_req and ext_req with wait_cnt<MAX_WAIT: CPU SHALL win; with wait_cnt==MAX_WAIT: ext SHALL win and CPU stalls.
REQ-019 Requests present in CPU_DATA/EXT_DATA (other than the CPU read completing) SHALL be stalled/unacked and arbitrated in the following IDLE cycle.
REQ-020 ext_req deasserted before ack SHALL cancel nothing already issued; an issued ext access SHALL still ack.

Reset
REQ-021 While rst=1 at a rising edge: state<=IDLE, wait_cnt<=0, ext_rdata<=0; in-flight accesses SHALL be dropped with no ack and no cpu_rdata delivery.
REQ-022 While rst=1, mem_wen, mem_ren, ext_ack, cpu_stall SHALL be 0, mem_addr, mem_wdata, cpu_rdata SHALL be 0.

Verification
REQ-023 CPU read alone: cpu_req=1, we=0, addr=0x10, mem returns 0xDEAD -> cycle0 mem_ren=1 stall=1; cycle1 cpu_rdata=0xDEAD stall=0.
REQ-024 CPU write alone: cpu_req=1, we=1, addr=0x8, wdata=0x55 -> same cycle mem_wen=1, mem_addr=0x8, stall=0, state stays IDLE.
REQ-025 Ext read alone: ext_req=1, addr=0x20, mem returns 0xBEEF -> cycle0 mem_ren=1; cycle1 ext_ack=1; from cycle2 ext_rdata=0xBEEF held.
REQ-026 Starvation, MAX_WAIT=4: ext_req held and CPU writes every cycle -> CPU granted 4 IDLE cycles, 5th cycle ext granted, cpu_stall=1 that cycle and the ack cycle, wait_cnt=0 after.
REQ-027 Reset mid-op: rst=1 in the cycle after an ext read issue -> no ext_ack, ext_rdata=0, state IDLE, all mem strobes 0.
